dmac_ctrl: RTL and testbench
============================

DMAC_CTRL -- requirements
Module: dmac_ctrl

Interface
REQ-001 Parameter LEN_W, default 16, width of the transfer byte-length field.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wren_i  input  1  register write enable, one access per cycle.
REQ-005 rden_i  input  1  register read enable.
REQ-006 addr_i  input  5  byte offset: 0x00 SRC, 0x04 DST, 0x08 LEN, 0x0C CMD, 0x10 STATUS.
REQ-007 wdata_i  input  32  write data.
REQ-008 rdata_o  output  32  read data, registered.
REQ-009 rvalid_o  output  1  high for one cycle when rdata_o is valid.
REQ-010 start_o  output  1  one-cycle pulse that launches the transfer engine.
REQ-011 src_addr_o  output  32  source address to the engine (SRC register).
REQ-012 dst_addr_o  output  32  destination address to the engine (DST register).
REQ-013 byte_len_o  output  LEN_W  transfer length to the engine (LEN[LEN_W-1:0]).
REQ-014 done_i  input  1  one-cycle pulse from the engine at transfer completion.
REQ-015 irq_o  output  1  level interrupt: STATUS.done AND CMD.irq_en.

Function
REQ-016 The FSM SHALL have states IDLE, START, BUSY and DONE.
REQ-017 In IDLE, a CMD write with wdata_i[0]=1 and LEN!=0 SHALL move the FSM to START on the next edge.
REQ-018 In IDLE, a CMD write with wdata_i[0]=1 and LEN==0 SHALL move the FSM directly to DONE without asserting start_o.
REQ-019 START SHALL last exactly one cycle, assert start_o, and then move to BUSY.
REQ-020 BUSY SHALL hold until done_i=1, then move to DONE.
REQ-021 DONE SHALL set STATUS.done (sticky), clear busy, and move to IDLE on the next cycle.
REQ-022 CMD bit1 (irq_en) SHALL be stored on every CMD write; CMD bit0 (go) SHALL be self-clearing and SHALL read as 0.
REQ-023 STATUS fields SHALL be: bit0 busy (state!=IDLE), bit1 done, bit2 err; bits 31:3 read 0.
REQ-024 STATUS.done and STATUS.err SHALL be write-1-to-clear; writing 0 to a bit SHALL leave it unchanged.
REQ-025 SRC, DST, LEN and CMD writes while state!=IDLE SHALL be ignored and SHALL set STATUS.err.
REQ-026 done_i while in IDLE, START or DONE SHALL be ignored.
REQ-027 If a done set and a W1C clear of done occur in the same cycle, the set SHALL win.
REQ-028 A read SHALL return data on rdata_o with rvalid_o=1 exactly one cycle after rden_i, reflecting register state before any same-cycle write.
REQ-029 Simultaneous wren_i and rden_i SHALL both be serviced.
REQ-030 Reads or writes to unmapped offsets SHALL return 0 and have no effect.
REQ-031 src_addr_o, dst_addr_o and byte_len_o SHALL be stable from START through DONE.
REQ-032 LEN bits above LEN_W-1 SHALL be stored as 0 and read as 0.

Reset
REQ-033 When rst=1 on a clock edge, the FSM SHALL return to IDLE and all registers, including STATUS and irq_en, SHALL be cleared to 0.
REQ-034 While rst=1, start_o, rvalid_o, irq_o and rdata_o SHALL be 0.
REQ-035 Reset asserted during BUSY SHALL abandon the transfer, and a late done_i after reset SHALL be ignored.

Structure
REQ-036 Package dmac_ctrl_pkg SHALL hold the FSM state enum, the register offset constants and the STATUS bit indices.
REQ-037 The register file and FSM SHALL reside in the single module dmac_ctrl, with no sub-module.

Verification
REQ-038 Write SRC=0x1000, DST=0x2000, LEN=0x40, CMD=0x3 -> start_o pulses one cycle later with outputs 0x1000/0x2000/0x40; after done_i, STATUS reads 0x2 and irq_o=1.
REQ-039 Write CMD=0x1 with LEN=0 -> no start_o; STATUS.done=1 within two cycles; irq_o=0 because irq_en=0.
REQ-040 In BUSY, write SRC=0xDEAD -> SRC still reads 0x1000, STATUS=0x5; then write STATUS=0x4 -> STATUS=0x1.
REQ-041 Assert done_i in the same cycle as a STATUS=0x2 write -> done remains 1.
REQ-042 Assert rst during BUSY, then pulse done_i -> all registers read 0, no irq_o, FSM in IDLE.
REQ-043 Perform a read of an unmapped offset (0x14) -> rdata_o=0 with rvalid_o one cycle later; no register changes.

Source files
------------

// File: rtl/dmac_ctrl_pkg.sv
// dmac_ctrl_pkg: FSM states, register offsets and STATUS bit positions
package dmac_ctrl_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_BUSY  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;
    localparam logic [4:0] OFF_SRC    = 5'h00;
    localparam logic [4:0] OFF_DST    = 5'h04;
    localparam logic [4:0] OFF_LEN    = 5'h08;
    localparam logic [4:0] OFF_CMD    = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
endpackage

// File: rtl/dmac_ctrl.sv
// dmac_ctrl: DMA channel register file and launch FSM
module dmac_ctrl import dmac_ctrl_pkg::*; #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren_i,
    input  logic             rden_i,
    input  logic [4:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             rvalid_o,
    output logic             start_o,
    output logic [31:0]      src_addr_o,
    output logic [31:0]      dst_addr_o,
    output logic [LEN_W-1:0] byte_len_o,
    input  logic             done_i,
    output logic             irq_o
);
    logic [31:0]      r_src, r_dst, r_rdata;
    logic [LEN_W-1:0] r_len;
    logic             r_irq_en, r_done, r_err, r_rvalid;
    state_t           r_state, w_next;
    logic             w_idle, w_cfg_wr, w_go, w_set_done;
    logic [31:0]      w_status, w_rd;

    assign w_idle     = r_state == ST_IDLE;
    assign w_cfg_wr   = wren_i && (addr_i == OFF_SRC || addr_i == OFF_DST ||
                                   addr_i == OFF_LEN || addr_i == OFF_CMD);
    assign w_go       = w_idle && wren_i && addr_i == OFF_CMD && wdata_i[0];
    assign w_set_done = (w_go && r_len == '0) || (r_state == ST_BUSY && done_i);

    always_comb begin
        w_next = w_go ? (r_len != '0 ? ST_START : ST_DONE) :
                 r_state == ST_START             ? ST_BUSY :
                 (r_state == ST_BUSY && done_i)  ? ST_DONE :
                 r_state == ST_DONE              ? ST_IDLE : r_state;
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_BUSY] = !w_idle;
        w_status[STAT_DONE] = r_done;
        w_status[STAT_ERR]  = r_err;
        w_rd = addr_i == OFF_SRC    ? r_src :
               addr_i == OFF_DST    ? r_dst :
               addr_i == OFF_LEN    ? 32'(r_len) :
               addr_i == OFF_CMD    ? {30'b0, r_irq_en, 1'b0} :
               addr_i == OFF_STATUS ? w_status : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= rden_i;
            r_rdata  <= rden_i ? w_rd : '0;
            if (w_idle && wren_i && addr_i == OFF_SRC) r_src <= wdata_i;
            if (w_idle && wren_i && addr_i == OFF_DST) r_dst <= wdata_i;
            if (w_idle && wren_i && addr_i == OFF_LEN) r_len <= wdata_i[LEN_W-1:0];
            if (w_idle && wren_i && addr_i == OFF_CMD) r_irq_en <= wdata_i[1];
            if (wren_i && addr_i == OFF_STATUS && wdata_i[STAT_DONE]) r_done <= 1'b0;
            if (wren_i && addr_i == OFF_STATUS && wdata_i[STAT_ERR]) r_err <= 1'b0;
            if (w_cfg_wr && !w_idle) r_err <= 1'b1;
            // completion outranks a same-cycle write-1-to-clear
            if (w_set_done) r_done <= 1'b1;
        end
    end

    assign rdata_o    = rst ? '0 : r_rdata;
    assign rvalid_o   = r_rvalid && !rst;
    assign start_o    = r_state == ST_START && !rst;
    assign irq_o      = r_done && r_irq_en && !rst;
    assign src_addr_o = r_src;
    assign dst_addr_o = r_dst;
    assign byte_len_o = r_len;
endmodule

// File: tb/tb_dmac_ctrl.sv
// tb_dmac_ctrl: directed scenarios plus random traffic against a transaction-level model
module tb_dmac_ctrl;
    localparam int LW = 16;
    logic          clk = 0, rst = 1, wren_i = 0, rden_i = 0, done_i = 0;
    logic [4:0]    addr_i = '0;
    logic [31:0]   wdata_i = '0;
    logic [31:0]   rdata_o, src_addr_o, dst_addr_o;
    logic          rvalid_o, start_o, irq_o;
    logic [LW-1:0] byte_len_o;

    dmac_ctrl #(.LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .wren_i(wren_i), .rden_i(rden_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .start_o(start_o),
        .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .byte_len_o(byte_len_o),
        .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 launch cycle, 2 waiting on engine, 3 completion cycle
    logic [31:0]   m_src, m_dst, m_rdata;
    logic [LW-1:0] m_len;
    bit            m_irq, m_done, m_err, m_rvalid;
    int            m_ph;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'h00:   return m_src;
            5'h04:   return m_dst;
            5'h08:   return 32'(m_len);
            5'h0C:   return {30'b0, m_irq, 1'b0};
            5'h10:   return {29'b0, m_err, m_done, m_ph != 0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        int prev;
        bit go;
        if (rst) begin
            m_src = 0; m_dst = 0; m_len = 0; m_irq = 0; m_done = 0; m_err = 0;
            m_ph = 0; m_rvalid = 0; m_rdata = 0;
            return;
        end
        prev = m_ph;
        go = m_ph == 0 && wren_i && addr_i == 5'h0C && wdata_i[0];
        m_rvalid = rden_i;
        if (rden_i) m_rdata = m_read(addr_i);
        if (wren_i && addr_i inside {5'h00, 5'h04, 5'h08, 5'h0C}) begin
            if (m_ph != 0) m_err = 1;
            else if (addr_i == 5'h00) m_src = wdata_i;
            else if (addr_i == 5'h04) m_dst = wdata_i;
            else if (addr_i == 5'h08) m_len = LW'(wdata_i % (32'd1 << LW));
            else m_irq = wdata_i[1];
        end
        if (wren_i && addr_i == 5'h10) begin
            if (wdata_i[1]) m_done = 0;
            if (wdata_i[2]) m_err = 0;
        end
        if (prev == 0 && go) m_ph = (m_len == 0) ? 3 : 1;
        else if (prev == 1) m_ph = 2;
        else if (prev == 2 && done_i) m_ph = 3;
        else if (prev == 3) m_ph = 0;
        if (m_ph == 3 && prev != 3) m_done = 1;
    endtask

    task automatic cyc(input bit w, input bit r, input logic [4:0] a, input logic [31:0] d,
                       input bit dn, input bit rs);
        wren_i = w; rden_i = r; addr_i = a; wdata_i = d; done_i = dn; rst = rs;
        @(posedge clk);
        #1;
        model_edge();
        check("start", start_o, m_ph == 1 && !rst);
        check("irq", irq_o, m_done && m_irq && !rst);
        check("rvalid", rvalid_o, m_rvalid && !rst);
        check("rdata", rdata_o, (m_rvalid && !rst) ? m_rdata : 32'h0);
        check("src", src_addr_o, m_src);
        check("dst", dst_addr_o, m_dst);
        check("len", 32'(byte_len_o), 32'(m_len));
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        int          k;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("rst_status", {29'b0, dut.r_err, dut.r_done, 1'b0}, 32'h0);
        // basic launch and completion with irq enabled
        cyc(1, 0, 5'h00, 32'h1000, 0, 0);
        cyc(1, 0, 5'h04, 32'h2000, 0, 0);
        cyc(1, 0, 5'h08, 32'h40, 0, 0);
        cyc(1, 0, 5'h0C, 32'h3, 0, 0);
        check("go_start", start_o, 1);
        check("go_src", src_addr_o, 32'h1000);
        check("go_dst", dst_addr_o, 32'h2000);
        check("go_len", 32'(byte_len_o), 32'h40);
        cyc(0, 0, 0, 0, 0, 0);
        check("start_once", start_o, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5'h10, 0, 0, 0);
        check("done_status", rdata_o, 32'h2);
        check("done_irq", irq_o, 1);
        // config write while busy is dropped and flags err
        cyc(1, 0, 5'h10, 32'h2, 0, 0);
        cyc(1, 0, 5'h0C, 32'h3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 5'h00, 32'hDEAD, 0, 0);
        cyc(0, 1, 5'h00, 0, 0, 0);
        check("busy_src", rdata_o, 32'h1000);
        cyc(0, 1, 5'h10, 0, 0, 0);
        check("busy_err", rdata_o, 32'h5);
        cyc(1, 0, 5'h10, 32'h4, 0, 0);
        cyc(0, 1, 5'h10, 0, 0, 0);
        check("err_clr", rdata_o, 32'h1);
        // done set beats same-cycle clear
        cyc(1, 0, 5'h10, 32'h2, 1, 0);
        cyc(0, 1, 5'h10, 0, 0, 0);
        check("set_wins", rdata_o[1], 1);
        // zero-length command completes without a launch
        cyc(1, 0, 5'h10, 32'h2, 0, 0);
        cyc(1, 0, 5'h08, 32'h0, 0, 0);
        cyc(1, 0, 5'h0C, 32'h1, 0, 0);
        check("zero_nostart", start_o, 0);
        cyc(0, 1, 5'h10, 0, 0, 0);
        check("zero_done", rdata_o[1], 1);
        check("zero_noirq", irq_o, 0);
        // unmapped offset
        cyc(1, 0, 5'h14, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 1, 5'h14, 0, 0, 0);
        check("unmap_rdata", rdata_o, 32'h0);
        check("unmap_rvalid", rvalid_o, 1);
        check("unmap_src", src_addr_o, 32'h1000);
        // reset while busy, then a late done
        cyc(1, 0, 5'h08, 32'h8, 0, 0);
        cyc(1, 0, 5'h0C, 32'h3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5'h10, 0, 0, 1);
        check("rst_rvalid", rvalid_o, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 5'(i * 4), 0, 0, 0);
            check("rst_reg", rdata_o, 32'h0);
        end
        check("rst_irq", irq_o, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 6);
            a = (k == 6) ? 5'($urandom) : 5'(k * 4);
            d = $urandom;
            if (a == 5'h08) d = ($urandom_range(0, 2) == 0) ? 32'h0 : (d & 32'h0003_00FF);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d,
                $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
